// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer controller.
// Used by led_sequencer_ctrl; the SINGLE_STEP_EN build fills the step field.
package led_seq_pkg;

    typedef enum logic [1:0] {
        CHASE_FWD = 2'd0,
        CHASE_REV = 2'd1,
        BOUNCE    = 2'd2,
        BLINK     = 2'd3
    } mode_t;

    localparam int SPEED_MAX = 3;
    localparam int NUM_LEDS  = 4;

    // One-cycle pulses from the edge detectors, one field per button
    typedef struct packed {
        logic mode;
        logic pause;
        logic speed_up;
        logic speed_down;
        logic step;
    } btn_edge_t;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle step enable every (TICK_DIV >> speed) clocks.
// Held at zero while paused; cleared by any user event so a full period follows.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic       hold,
    input  logic       clear,
    output logic       tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    always_comb begin
        case (speed)
            2'd0:    last = CNT_W'(TICK_DIV - 1);
            2'd1:    last = CNT_W'((TICK_DIV >> 1) - 1);
            2'd2:    last = CNT_W'((TICK_DIV >> 2) - 1);
            default: last = CNT_W'((TICK_DIV >> 3) - 1);
        endcase
    end

    assign tick = ~hold & (cnt == last);

    always_ff @(posedge clk) begin
        if (reset || clear || hold || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_sequencer_ctrl.sv
// Button-driven 4-LED pattern sequencer stepping on a prescaled clock enable.
// Optional macro SINGLE_STEP_EN adds stepBtn: one step per press while paused.
module led_sequencer_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       resetBtn,
    input  logic       modeBtn,
    input  logic       pauseBtn,
    input  logic       speedUpBtn,
    input  logic       speedDownBtn,
`ifdef SINGLE_STEP_EN
    input  logic       stepBtn,
`endif
    output logic       led0,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] mode
);

`ifdef SINGLE_STEP_EN
    localparam int NUM_BTN = 5;
`else
    localparam int NUM_BTN = 4;
`endif

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] pulse;
    btn_edge_t          edges;

`ifdef SINGLE_STEP_EN
    assign btn_raw = {stepBtn, speedDownBtn, speedUpBtn, pauseBtn, modeBtn};
`else
    assign btn_raw = {speedDownBtn, speedUpBtn, pauseBtn, modeBtn};
`endif

    // Two-flop synchroniser followed by a rising-edge detector per button
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_sync
        logic s1, s2, s3;
        always_ff @(posedge clk) begin
            if (resetBtn) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
                s3 <= 1'b0;
            end else begin
                s1 <= btn_raw[i];
                s2 <= s1;
                s3 <= s2;
            end
        end
        assign pulse[i] = s2 & ~s3;
    end

    assign edges.mode       = pulse[0];
    assign edges.pause      = pulse[1];
    assign edges.speed_up   = pulse[2];
    assign edges.speed_down = pulse[3];
`ifdef SINGLE_STEP_EN
    assign edges.step       = pulse[4];
`else
    assign edges.step       = 1'b0;
`endif

    mode_t      mode_state;
    logic [1:0] pos;
    logic       dir_down;
    logic       phase;
    logic [1:0] speed;
    logic       paused;
    logic       tick;
    logic       speed_evt;
    logic       any_evt;
    logic       advance;

    assign speed_evt = edges.speed_up | edges.speed_down;
    assign any_evt   = edges.mode | edges.pause | speed_evt;

`ifdef SINGLE_STEP_EN
    assign advance = tick | (paused & edges.step);
`else
    assign advance = tick;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (resetBtn),
        .speed (speed),
        .hold  (paused),
        .clear (any_evt),
        .tick  (tick)
    );

    // Event chain in priority order; a tick sharing a cycle with a press is dropped
    always_ff @(posedge clk) begin
        if (resetBtn) begin
            mode_state <= CHASE_FWD;
            pos        <= 2'd0;
            dir_down   <= 1'b0;
            phase      <= 1'b0;
            speed      <= 2'd0;
            paused     <= 1'b0;
        end else if (edges.mode) begin
            mode_state <= next_mode(mode_state);
            pos        <= 2'd0;
            dir_down   <= 1'b0;
            phase      <= 1'b0;
        end else if (edges.pause) begin
            paused <= ~paused;
        end else if (speed_evt) begin
            if (edges.speed_up && !edges.speed_down && speed != 2'(SPEED_MAX)) begin
                speed <= speed + 2'd1;
            end else if (edges.speed_down && !edges.speed_up && speed != 2'd0) begin
                speed <= speed - 2'd1;
            end
        end else if (advance) begin
            case (mode_state)
                CHASE_FWD: pos <= pos + 2'd1;
                CHASE_REV: pos <= pos - 2'd1;
                BOUNCE: begin
                    if (!dir_down && pos == 2'd3) begin
                        dir_down <= 1'b1;
                        pos      <= 2'd2;
                    end else if (dir_down && pos == 2'd0) begin
                        dir_down <= 1'b0;
                        pos      <= 2'd1;
                    end else if (dir_down) begin
                        pos <= pos - 2'd1;
                    end else begin
                        pos <= pos + 2'd1;
                    end
                end
                default: phase <= ~phase;
            endcase
        end
    end

    logic [NUM_LEDS-1:0] led_vec;

    always_comb begin
        led_vec = '0;
        if (mode_state == BLINK) begin
            led_vec = {NUM_LEDS{phase}};
        end else begin
            led_vec[pos] = 1'b1;
        end
    end

    assign {led3, led2, led1, led0} = led_vec;
    assign mode = mode_state;

endmodule
